pkt2msg_arbiter: RTL and testbench

PKT2MSG_ARBITER -- requirements
Module: pkt2msg_arbiter

---
 rtl/pkt2msg_arbiter.sv | 101 ++++++++++
 tb/tb_pkt2msg_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pkt2msg_arbiter.sv
// Round-robin arbiter moving whole packets from N_VC flit buffers
// into a single registered message slot with valid/ready handoff.
module pkt2msg_arbiter #(
    parameter int N_VC              = 2,
    parameter int N_BITS_VC         = 1,
    parameter int FLIT_WIDTH        = 8,
    parameter int MAX_PACKET_LENGHT = 4,
    localparam int PKT_W            = MAX_PACKET_LENGHT * FLIT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_VC-1:0]           r_pkt_to_msg_i,
    output logic [N_VC-1:0]           g_pkt_to_msg_o,
    input  logic [N_VC*PKT_W-1:0]     pkt_link_i,
    output logic                      msg_valid_o,
    input  logic                      msg_ready_i,
    output logic [PKT_W-1:0]          msg_link_o,
    output logic [N_BITS_VC-1:0]      msg_vc_o,
    output logic [15:0]               pkt_count_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state, state_next;
    logic [N_BITS_VC-1:0]  rr_ptr, rr_next;
    logic [N_BITS_VC-1:0]  win;
    logic                  found;
    logic                  grant_ok;
    logic                  accept;
    int                    idx;

    // Reset also blocks the combinational grant path.
    assign grant_ok = !rst && ((state == EMPTY) || msg_ready_i);
    assign accept   = msg_valid_o && msg_ready_i;

    always_comb begin
        g_pkt_to_msg_o = '0;
        win            = '0;
        found          = 1'b0;
        idx            = 0;
        if (grant_ok) begin
            for (int k = 0; k < N_VC; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_VC)
                    idx = idx - N_VC;
                if (!found && r_pkt_to_msg_i[idx]) begin
                    found               = 1'b1;
                    win                 = N_BITS_VC'(idx);
                    g_pkt_to_msg_o[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_next = rr_ptr;
        if (found) begin
            if (int'(win) == N_VC - 1)
                rr_next = '0;
            else
                rr_next = win + N_BITS_VC'(1);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: if (found) state_next = FULL;
            FULL: begin
                if (msg_ready_i)
                    state_next = found ? FULL : EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            rr_ptr      <= '0;
            msg_valid_o <= 1'b0;
            msg_link_o  <= '0;
            msg_vc_o    <= '0;
            pkt_count_o <= '0;
        end else begin
            state       <= state_next;
            rr_ptr      <= rr_next;
            msg_valid_o <= (state_next == FULL);
            if (found) begin
                msg_link_o <= pkt_link_i[int'(win)*PKT_W +: PKT_W];
                msg_vc_o   <= win;
            end
            if (accept && pkt_count_o != 16'hFFFF)
                pkt_count_o <= pkt_count_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_pkt2msg_arbiter.sv
// Directed bench for pkt2msg_arbiter: grants, round-robin, backpressure,
// drain, async reset and count saturation with N_VC=2, 32-bit packets.
module tb_pkt2msg_arbiter;

    localparam int PKT_W = 32;
    localparam logic [PKT_W-1:0] PA = 32'hA1A2A3A4;
    localparam logic [PKT_W-1:0] PB = 32'hB1B2B3B4;

    logic             clk;
    logic             rst;
    logic [1:0]       r;
    logic [1:0]       g;
    logic [2*PKT_W-1:0] pkt;
    logic             valid;
    logic             ready;
    logic [PKT_W-1:0] link;
    logic [0:0]       vc;
    logic [15:0]      count;

    int checks = 0;
    int errors = 0;

    pkt2msg_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .r_pkt_to_msg_i (r),
        .g_pkt_to_msg_o (g),
        .pkt_link_i     (pkt),
        .msg_valid_o    (valid),
        .msg_ready_i    (ready),
        .msg_link_o     (link),
        .msg_vc_o       (vc),
        .pkt_count_o    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        r     = 2'b00;
        ready = 1'b0;
        pkt   = {PA, PB};
        #2 r  = 2'b11;
        #1;
        chk("rst_g", 64'(g), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_vc", 64'(vc), 64'd0);
        chk("rst_link", 64'(link), 64'd0);

        @(negedge clk);
        r   = 2'b00;
        rst = 1'b0;

        // single request on channel 1
        @(negedge clk);
        r = 2'b10; ready = 1'b1;
        #1;
        chk("single_g", 64'(g), 64'h2);
        chk("single_valid0", 64'(valid), 64'd0);
        @(negedge clk);
        r = 2'b00;
        #1;
        chk("single_valid", 64'(valid), 64'd1);
        chk("single_link", 64'(link), 64'(PA));
        chk("single_vc", 64'(vc), 64'd1);
        chk("single_cnt0", 64'(count), 64'd0);
        @(negedge clk);
        #1;
        chk("single_cnt1", 64'(count), 64'd1);
        chk("single_drain", 64'(valid), 64'd0);

        // round-robin with both requesting
        @(negedge clk);
        r = 2'b11;
        #1;
        chk("rr_g1", 64'(g), 64'h1);
        @(negedge clk);
        #1;
        chk("rr_g2", 64'(g), 64'h2);
        chk("rr_v2", 64'(valid), 64'd1);
        chk("rr_vc2", 64'(vc), 64'd0);
        @(negedge clk);
        #1;
        chk("rr_g3", 64'(g), 64'h1);
        chk("rr_vc3", 64'(vc), 64'd1);
        chk("rr_link3", 64'(link), 64'(PA));
        @(negedge clk);
        #1;
        chk("rr_g4", 64'(g), 64'h2);
        chk("rr_v4", 64'(valid), 64'd1);
        @(negedge clk);
        r = 2'b00;
        #1;
        chk("rr_g5", 64'(g), 64'd0);
        chk("rr_v5", 64'(valid), 64'd1);
        chk("rr_vc5", 64'(vc), 64'd1);

        // drain: slot empties, one more accept, pointer untouched
        @(negedge clk);
        #1;
        chk("drain_valid", 64'(valid), 64'd0);
        chk("drain_cnt", 64'(count), 64'd5);

        // backpressure
        @(negedge clk);
        r = 2'b11;
        #1;
        chk("bp_g0", 64'(g), 64'h1);
        @(negedge clk);
        r = 2'b10; ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_g_stall", 64'(g), 64'd0);
            chk("bp_link", 64'(link), 64'(PB));
            chk("bp_vc", 64'(vc), 64'd0);
            chk("bp_valid", 64'(valid), 64'd1);
            @(negedge clk);
        end
        ready = 1'b1;
        #1;
        chk("bp_g_go", 64'(g), 64'h2);
        @(negedge clk);
        r = 2'b00;
        #1;
        chk("bp_vc1", 64'(vc), 64'd1);
        chk("bp_link1", 64'(link), 64'(PA));
        chk("bp_cnt", 64'(count), 64'd6);
        @(negedge clk);
        #1;
        chk("bp_cnt2", 64'(count), 64'd7);
        chk("bp_empty", 64'(valid), 64'd0);

        // async reset while full
        @(negedge clk);
        r = 2'b01;
        #1;
        chk("ar_g", 64'(g), 64'h1);
        @(negedge clk);
        r = 2'b00; ready = 1'b0;
        #1;
        chk("ar_full", 64'(valid), 64'd1);
        rst = 1'b1;
        r   = 2'b11;
        #1;
        chk("ar_valid", 64'(valid), 64'd0);
        chk("ar_cnt", 64'(count), 64'd0);
        chk("ar_g0", 64'(g), 64'd0);
        rst = 1'b0;
        #1;
        chk("ar_first_g", 64'(g), 64'h1);
        @(negedge clk);
        r = 2'b00; ready = 1'b1;
        #1;
        chk("ar_v", 64'(valid), 64'd1);
        chk("ar_vc", 64'(vc), 64'd0);
        chk("ar_link", 64'(link), 64'(PB));
        chk("ar_cnt0", 64'(count), 64'd0);
        @(negedge clk);
        #1;
        chk("ar_cnt1", 64'(count), 64'd1);

        // saturation: stream channel 0 at one packet per cycle
        @(negedge clk);
        r = 2'b01; ready = 1'b1;
        repeat (65533) @(negedge clk);
        #1;
        chk("sat_fffd", 64'(count), 64'hFFFD);
        @(negedge clk);
        #1;
        chk("sat_fffe", 64'(count), 64'hFFFE);
        @(negedge clk);
        #1;
        chk("sat_ffff", 64'(count), 64'hFFFF);
        @(negedge clk);
        #1;
        chk("sat_hold1", 64'(count), 64'hFFFF);
        @(negedge clk);
        #1;
        chk("sat_hold2", 64'(count), 64'hFFFF);
        chk("sat_g", 64'(g), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
